// File: rtl/posterise_pkg.sv
// Shared constants and state encoding for the posterise mode controller.
// Mode codes are also consumed by the posterise datapath.
package posterise_pkg;

  localparam logic [2:0] MODE_BYPASS = 3'd0;
  localparam logic [2:0] MODE_LVL1   = 3'd1;
  localparam logic [2:0] MODE_LVL2   = 3'd2;
  localparam logic [2:0] MODE_LVL3   = 3'd3;
  localparam logic [2:0] MODE_LVL4   = 3'd4;
  localparam logic [2:0] MODE_LVL5   = 3'b101;

  localparam logic [2:0] MAX_LEVEL = 3'd5;

  typedef enum logic [1:0] {
    BYPASS,
    MANUAL,
    AUTO_UP,
    AUTO_DOWN
  } state_t;

  function automatic logic is_auto(state_t s);
    return (s == AUTO_UP) || (s == AUTO_DOWN);
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Normalises vsync polarity and emits a one-cycle pulse on entry
// into the active level.
module frame_edge_det #(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic frame_start
);

  logic vs_act;
  logic prev_act;

  assign vs_act = (vsync == VSYNC_POL);

  // History resets to active so a held vsync never looks like an edge
  always_ff @(posedge clk) begin
    if (rst) prev_act <= 1'b1;
    else     prev_act <= vs_act;
  end

  assign frame_start = vs_act & ~prev_act;

endmodule

// File: rtl/posterise_ctrl.sv
// Posterise mode controller: shadowed config committed at frame start,
// manual stepping and an auto ping-pong sweep over levels 1..5.
module posterise_ctrl
  import posterise_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               cfg_wr,
  input  logic               cfg_auto,
  input  logic [2:0]         cfg_level,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               btn_next,
  output logic [2:0]         mode,
  output logic               mode_changed,
  output logic               auto_active
);

  logic frame_start;

  frame_edge_det #(
    .VSYNC_POL(VSYNC_POL)
  ) u_edge (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  state_t             state, nxt_state;
  logic [2:0]         level, nxt_level;
  logic [DWELL_W-1:0] dwell_cnt, nxt_dwell_cnt;
  logic               sh_auto, nxt_sh_auto;
  logic [2:0]         sh_level, nxt_sh_level;
  logic [DWELL_W-1:0] sh_dwell, nxt_sh_dwell;
  logic               pending, nxt_pending;
  logic [2:0]         nxt_mode;

  logic               commit;
  logic               set_pend;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W:0]   cnt_inc;
  logic               expire;

  assign commit    = frame_start & pending;
  assign dwell_eff = (sh_dwell == '0) ? DWELL_W'(1) : sh_dwell;
  assign cnt_inc   = {1'b0, dwell_cnt} + 1'b1;
  assign expire    = cnt_inc >= {1'b0, dwell_eff};

  // Shadow registers; cfg_wr beats a same-cycle btn_next
  always_comb begin
    nxt_sh_auto  = sh_auto;
    nxt_sh_level = sh_level;
    nxt_sh_dwell = sh_dwell;
    set_pend     = 1'b0;
    if (cfg_wr) begin
      nxt_sh_auto  = cfg_auto;
      nxt_sh_level = (cfg_level > MAX_LEVEL) ? MODE_BYPASS : cfg_level;
      nxt_sh_dwell = cfg_dwell;
      set_pend     = 1'b1;
    end else if (btn_next && !sh_auto) begin
      nxt_sh_level = (sh_level >= MAX_LEVEL) ? MODE_BYPASS
                                             : sh_level + 3'd1;
      set_pend     = 1'b1;
    end
    nxt_pending = set_pend | (pending & ~commit);
  end

  always_comb begin
    nxt_state     = state;
    nxt_level     = level;
    nxt_dwell_cnt = dwell_cnt;
    if (commit) begin
      nxt_dwell_cnt = '0;
      if (sh_auto) begin
        nxt_state = AUTO_UP;
        nxt_level = MODE_LVL1;
      end else if (sh_level == MODE_BYPASS) begin
        nxt_state = BYPASS;
        nxt_level = MODE_BYPASS;
      end else begin
        nxt_state = MANUAL;
        nxt_level = sh_level;
      end
    end else if (frame_start && is_auto(state)) begin
      if (!expire) begin
        nxt_dwell_cnt = cnt_inc[DWELL_W-1:0];
      end else begin
        nxt_dwell_cnt = '0;
        unique case (state)
          AUTO_UP: begin
            nxt_level = level + 3'd1;
            if (level + 3'd1 == MAX_LEVEL) nxt_state = AUTO_DOWN;
          end
          AUTO_DOWN: begin
            nxt_level = level - 3'd1;
            if (level - 3'd1 == MODE_LVL1) nxt_state = AUTO_UP;
          end
          default: ;
        endcase
      end
    end
    nxt_mode = (nxt_state == BYPASS) ? MODE_BYPASS : nxt_level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BYPASS;
      level        <= MODE_BYPASS;
      dwell_cnt    <= '0;
      sh_auto      <= 1'b0;
      sh_level     <= MODE_BYPASS;
      sh_dwell     <= '0;
      pending      <= 1'b0;
      mode         <= MODE_BYPASS;
      mode_changed <= 1'b0;
      auto_active  <= 1'b0;
    end else begin
      state        <= nxt_state;
      level        <= nxt_level;
      dwell_cnt    <= nxt_dwell_cnt;
      sh_auto      <= nxt_sh_auto;
      sh_level     <= nxt_sh_level;
      sh_dwell     <= nxt_sh_dwell;
      pending      <= nxt_pending;
      mode         <= nxt_mode;
      mode_changed <= (nxt_mode != mode);
      auto_active  <= is_auto(nxt_state);
    end
  end

endmodule
